// File: rtl/keypad_scanner_fifo.sv
// ---------------------------------------------------------------------------
// keypad_scanner_fifo
// Matrix keypad scanner with press/release debounce and a small key-code
// FIFO behind a CPU register interface.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   keyboardCtrl     in   chip select, qualifies CPU reads only
//   read_enable      in   CPU read strobe
//   address[3:0]     in   0x0 data (pops), 0x2 status (clears overflow)
//   column[COLS-1:0] in   column sense, active-low, idle high
//   row[ROWS-1:0]    out  row drive, active-low
//   read_data_output out  registered read data, held between reads
//   key_irq          out  registered, high while the FIFO holds a code
// ---------------------------------------------------------------------------
module keypad_scanner_fifo #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            keyboardCtrl,
  input  logic            read_enable,
  input  logic [3:0]      address,
  input  logic [COLS-1:0] column,
  output logic [ROWS-1:0] row,
  output logic [15:0]     read_data_output,
  output logic            key_irq
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DBW-1:0] DEB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]     ROW_LAST    = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_SCAN     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Lowest column index reading low; the scan order already gives lowest row.
  function automatic logic [3:0] first_low_col(input logic [COLS-1:0] col);
    logic [3:0] idx;
    idx = 4'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col[c]) begin
        idx = 4'(c);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Active-low drive pattern with only row idx pulled low.
  function automatic logic [ROWS-1:0] row_drive(input logic [3:0] idx);
    logic [ROWS-1:0] p;
    for (int r = 0; r < ROWS; r++) begin
      p[r] = (4'(r) != idx);
    end
    return p;
  endfunction

  state_t          state_q;
  logic [ROWS-1:0] row_q;
  logic [3:0]      row_idx_q;
  logic [DBW-1:0]  deb_cnt_q;
  logic [SW-1:0]   settle_cnt_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic            col_active_s;
  logic            push_s;
  logic [7:0]      code_s;
  logic            rd_qual_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;
  logic            ovf_set_s;
  logic            stat_rd_s;

  // Key-detect and record strobes derived from the scanner state.
  always_comb begin
    col_active_s = ~&column;
    push_s       = (state_q == ST_SCAN) && (settle_cnt_q == SETTLE_LAST) && col_active_s;
    code_s       = {row_idx_q, first_low_col(column)};
  end

  // Scanner FSM: debounce press, walk the rows, debounce release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      row_idx_q    <= 4'd0;
      deb_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          row_q     <= '0;
          deb_cnt_q <= '0;
          if (col_active_s) begin
            state_q <= ST_DEBOUNCE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (!col_active_s) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q      <= ST_SCAN;
            deb_cnt_q    <= '0;
            row_idx_q    <= 4'd0;
            row_q        <= row_drive(4'd0);
            settle_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DBW'(1);
          end
        end
        ST_SCAN: begin
          if (settle_cnt_q != SETTLE_LAST) begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end else if (col_active_s) begin
            // Hit: code is pushed this cycle, then wait for full release.
            state_q   <= ST_RELEASE;
            row_q     <= '0;
            deb_cnt_q <= '0;
          end else if (row_idx_q == ROW_LAST) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
          end else begin
            row_idx_q    <= row_idx_q + 4'd1;
            row_q        <= row_drive(row_idx_q + 4'd1);
            settle_cnt_q <= '0;
          end
        end
        ST_RELEASE: begin
          row_q <= '0;
          if (col_active_s) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DBW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          row_q   <= '0;
        end
      endcase
    end
  end

  // FIFO bookkeeping, register reads and interrupt next-state.
  always_comb begin
    rd_qual_s = read_enable && keyboardCtrl;
    pop_s     = rd_qual_s && (address == 4'h0) && (count_q != '0);
    full_s    = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok_s = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    stat_rd_s = rd_qual_s && (address == 4'h2);

    if (push_ok_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A same-cycle overflow survives the status read that clears the old one.
    ovf_d = ovf_set_s | (ovf_q & ~stat_rd_s);

    if (rd_qual_s) begin
      case (address)
        4'h0: begin
          if (count_q != '0) begin
            rdata_d = {1'b1, 7'd0, mem_q[rd_ptr_q]};
          end else begin
            rdata_d = 16'h0000;
          end
        end
        4'h2:    rdata_d = {8'd0, ovf_q, full_s, 1'b0, 5'(count_q)};
        default: rdata_d = 16'h0000;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    irq_d = (count_d != '0);
  end

  // FIFO control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= 16'h0000;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) begin
      mem_q[wr_ptr_q] <= code_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign row              = row_q;
  assign read_data_output = rdata_q;
  assign key_irq          = irq_q;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Directed bench for keypad_scanner_fifo with a 4x4 key matrix model.
module tb_keypad_scanner_fifo;

  logic        clock;
  logic        reset;
  logic        keyboardCtrl;
  logic        read_enable;
  logic [3:0]  address;
  logic [3:0]  column;
  logic [3:0]  row;
  logic [15:0] read_data_output;
  logic        key_irq;

  logic [15:0] keys;      // bit r*4+c set = key at row r / column c held
  logic [15:0] rd;
  int          n_checks;
  int          n_errors;

  keypad_scanner_fifo #(
    .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2), .FIFO_DEPTH(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .keyboardCtrl    (keyboardCtrl),
    .read_enable     (read_enable),
    .address         (address),
    .column          (column),
    .row             (row),
    .read_data_output(read_data_output),
    .key_irq         (key_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A held key pulls its column low whenever its row is driven low.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      column[c] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c] && !row[r]) column[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One-cycle register read; starts and ends at a falling edge.
  task automatic do_read(input logic [3:0] a, input logic ctrl, output logic [15:0] d);
    keyboardCtrl = ctrl;
    address      = a;
    read_enable  = 1'b1;
    @(negedge clock);
    read_enable  = 1'b0;
    keyboardCtrl = 1'b0;
    d            = read_data_output;
  endtask

  // Hold the keys in mask for 50 cycles, then release and let the release
  // debounce finish. If sync_row >= 0, a data read is issued in exactly the
  // cycle the scanner samples that row (press + 7 + 2*row edges).
  task automatic press(input logic [15:0] mask, input int sync_row, output logic [15:0] d);
    d    = 16'h0000;
    keys = mask;
    if (sync_row >= 0) begin
      repeat (6 + 2*sync_row) @(negedge clock);
      do_read(4'h0, 1'b1, d);
      repeat (43 - 2*sync_row) @(negedge clock);
    end else begin
      repeat (50) @(negedge clock);
    end
    keys = 16'h0000;
    repeat (12) @(negedge clock);
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] m;
    m = 16'h0000;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  initial begin
    int waited;
    n_checks     = 0;
    n_errors     = 0;
    keys         = 16'h0000;
    reset        = 1'b1;
    keyboardCtrl = 1'b0;
    read_enable  = 1'b0;
    address      = 4'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_row",   {12'd0, row}, 16'h0000);
    check("rst_rdata", read_data_output, 16'h0000);
    check("rst_irq",   {15'd0, key_irq}, 16'h0000);
    do_read(4'h2, 1'b1, rd);
    check("rst_status", rd, 16'h0000);

    // Single press row2/col1, held then released: one code only
    press(key_bit(2, 1), -1, rd);
    check("press_irq", {15'd0, key_irq}, 16'h0001);
    do_read(4'h2, 1'b1, rd);
    check("press_status_one", rd, 16'h0001);
    do_read(4'h0, 1'b1, rd);
    check("press_code", rd, 16'h8021);
    check("press_irq_clear", {15'd0, key_irq}, 16'h0000);
    do_read(4'h0, 1'b1, rd);
    check("empty_read", rd, 16'h0000);

    // Glitch shorter than the debounce
    keys = key_bit(0, 2);
    repeat (3) @(negedge clock);
    keys = 16'h0000;
    repeat (20) @(negedge clock);
    check("glitch_row_idle", {12'd0, row}, 16'h0000);
    do_read(4'h2, 1'b1, rd);
    check("glitch_status", rd, 16'h0000);

    // Two keys together: lowest row wins
    press(key_bit(1, 3) | key_bit(3, 0), -1, rd);
    do_read(4'h0, 1'b1, rd);
    check("multi_key_code", rd, 16'h8013);

    // Push and pop in the same cycle on an empty FIFO
    press(key_bit(0, 2), 0, rd);
    check("empty_pushpop_rd", rd, 16'h0000);
    do_read(4'h2, 1'b1, rd);
    check("empty_pushpop_status", rd, 16'h0001);
    do_read(4'h0, 1'b1, rd);
    check("empty_pushpop_code", rd, 16'h8002);

    // Five presses without reads: fifth overflows
    press(key_bit(0, 0), -1, rd);
    press(key_bit(0, 1), -1, rd);
    press(key_bit(1, 2), -1, rd);
    press(key_bit(2, 3), -1, rd);
    press(key_bit(3, 3), -1, rd);
    do_read(4'h2, 1'b1, rd);
    check("ovf_status", rd, 16'h00C4);
    do_read(4'h2, 1'b1, rd);
    check("ovf_cleared", rd, 16'h0044);

    // Push and pop in the same cycle on a full FIFO: both accepted
    press(key_bit(1, 1), 1, rd);
    check("full_pushpop_rd", rd, 16'h8000);
    do_read(4'h2, 1'b1, rd);
    check("full_pushpop_status", rd, 16'h0044);
    do_read(4'h0, 1'b1, rd);
    check("fifo_rd1", rd, 16'h8001);
    do_read(4'h0, 1'b1, rd);
    check("fifo_rd2", rd, 16'h8012);
    do_read(4'h0, 1'b1, rd);
    check("fifo_rd3", rd, 16'h8023);
    do_read(4'h0, 1'b1, rd);
    check("fifo_rd4_wrapped", rd, 16'h8011);
    do_read(4'h0, 1'b1, rd);
    check("fifo_drained", rd, 16'h0000);

    // Reserved address and deselected read
    do_read(4'h6, 1'b1, rd);
    check("reserved_addr", rd, 16'h0000);
    press(key_bit(3, 2), -1, rd);
    do_read(4'h2, 1'b1, rd);
    check("cs_pre_status", rd, 16'h0001);
    do_read(4'h0, 1'b0, rd);
    check("cs_low_hold", rd, 16'h0001);
    do_read(4'h2, 1'b1, rd);
    check("cs_low_no_pop", rd, 16'h0001);

    // Reset during SCAN
    keys   = key_bit(3, 3);
    waited = 0;
    while (row == 4'b0000 && waited < 30) begin
      @(negedge clock);
      waited++;
    end
    check("scan_entered", {15'd0, row != 4'b0000}, 16'h0001);
    reset = 1'b1;
    keys  = 16'h0000;
    @(negedge clock);
    reset = 1'b0;
    check("midscan_rst_row",   {12'd0, row}, 16'h0000);
    check("midscan_rst_rdata", read_data_output, 16'h0000);
    check("midscan_rst_irq",   {15'd0, key_irq}, 16'h0000);
    repeat (20) @(negedge clock);
    do_read(4'h2, 1'b1, rd);
    check("midscan_rst_status", rd, 16'h0000);
    do_read(4'h0, 1'b1, rd);
    check("midscan_rst_empty", rd, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
